tlb_unit: RTL and testbench

- Joint TLB for the SimMIPS core. It is the TLB-side counterpart of the CP0 register file.
- Consumes CP0 Index/Random/EntryHi/EntryLo0/EntryLo1/Status to execute TLBWI/TLBWR/TLBR/TLBP.
- Returns probe result and TLBR read-back (with write strobes) to CP0.
- Translates fetch/load/store virtual addresses with 1-cycle registered latency and raises the TLB/address-error exception lines that CP0 consumes.

---
 rtl/tlb_unit.sv | 205 ++++++++++++++++++++
 tb/tb_tlb_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/tlb_unit.sv
// Joint TLB for the SimMIPS core: executes TLBWI/TLBWR/TLBR/TLBP against CP0 state
// and translates virtual addresses with one cycle of registered latency.
module tlb_unit #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned IDX_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_pause_i,
  input  logic             instr_TLBWI_i,
  input  logic             instr_TLBWR_i,
  input  logic             instr_TLBR_i,
  input  logic             instr_TLBP_i,
  input  logic [31:0]      cp0_index_i,
  input  logic [31:0]      cp0_random_i,
  input  logic [31:0]      cp0_entryhi_i,
  input  logic [31:0]      cp0_entrylo0_i,
  input  logic [31:0]      cp0_entrylo1_i,
  input  logic [31:0]      cp0_status_i,
  input  logic             req_valid_i,
  input  logic [31:0]      req_vaddr_i,
  input  logic             req_write_i,
  output logic             resp_valid_o,
  output logic [31:0]      resp_paddr_o,
  output logic             exception_tlb_refill_o,
  output logic             exception_tlb_invalid_o,
  output logic             exception_tlb_mod_o,
  output logic             exception_addr_error_o,
  output logic             exception_tlb_rw_o,
  output logic             tlb_probe_success_o,
  output logic [IDX_W-1:0] tlb_probe_index_o,
  output logic [31:0]      tlb_entryhi_o,
  output logic [31:0]      tlb_entrylo0_o,
  output logic [31:0]      tlb_entrylo1_o,
  output logic             tlb_entryhi_wen_o,
  output logic             tlb_entrylo0_wen_o,
  output logic             tlb_entrylo1_wen_o
);

  localparam int unsigned PAGE_W = 25;  // {pfn[19:0], c[2:0], d, v} == entrylo[25:1]

  logic [ENTRIES-1:0] r_present;
  logic [18:0]        r_vpn2 [ENTRIES];
  logic [7:0]         r_asid [ENTRIES];
  logic               r_g    [ENTRIES];
  logic [PAGE_W-1:0]  r_lo   [ENTRIES][2];

  logic               r_resp_valid, r_refill, r_invalid, r_mod, r_addr_err, r_rw;
  logic [31:0]        r_paddr;
  logic               r_probe_ok;
  logic [IDX_W-1:0]   r_probe_idx;
  logic [31:0]        r_rd_hi, r_rd_lo0, r_rd_lo1;
  logic               r_rd_wen;

  logic               w_do_wi, w_do_wr, w_do_r, w_do_p, w_we;
  logic [IDX_W-1:0]   w_wr_idx, w_rd_idx;
  logic               w_tr_hit, w_pb_hit;
  logic [IDX_W-1:0]   w_tr_idx, w_pb_idx;
  logic [PAGE_W-1:0]  w_page;
  logic [31:0]        w_paddr;
  logic               w_refill, w_invalid, w_mod, w_addr_err;
  logic               w_unused;

  assign w_unused = ^{cp0_index_i[31:IDX_W], cp0_random_i[31:IDX_W], cp0_entryhi_i[12:8],
                      cp0_entrylo0_i[31:26], cp0_entrylo1_i[31:26], cp0_status_i[31:5],
                      cp0_status_i[3:0]};

  // Strobe priority: TLBWI > TLBWR > TLBR > TLBP
  assign w_do_wi  = instr_TLBWI_i;
  assign w_do_wr  = instr_TLBWR_i & ~instr_TLBWI_i;
  assign w_do_r   = instr_TLBR_i & ~instr_TLBWI_i & ~instr_TLBWR_i;
  assign w_do_p   = instr_TLBP_i & ~instr_TLBWI_i & ~instr_TLBWR_i & ~instr_TLBR_i;
  assign w_we     = ~cpu_pause_i & (w_do_wi | w_do_wr);
  assign w_wr_idx = w_do_wi ? cp0_index_i[IDX_W-1:0] : cp0_random_i[IDX_W-1:0];
  assign w_rd_idx = cp0_index_i[IDX_W-1:0];

  // Associative search; scanning downward leaves the lowest matching index
  always_comb begin
    w_tr_hit = 1'b0;
    w_tr_idx = '0;
    w_pb_hit = 1'b0;
    w_pb_idx = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (r_present[i] && r_vpn2[i] == req_vaddr_i[31:13] &&
          (r_g[i] || r_asid[i] == cp0_entryhi_i[7:0])) begin
        w_tr_hit = 1'b1;
        w_tr_idx = IDX_W'(i);
      end
      if (r_present[i] && r_vpn2[i] == cp0_entryhi_i[31:13] &&
          (r_g[i] || r_asid[i] == cp0_entryhi_i[7:0])) begin
        w_pb_hit = 1'b1;
        w_pb_idx = IDX_W'(i);
      end
    end
  end

  assign w_page = r_lo[w_tr_idx][req_vaddr_i[12]];

  // Address classification and exception selection; at most one flag is raised
  always_comb begin
    w_paddr    = '0;
    w_refill   = 1'b0;
    w_invalid  = 1'b0;
    w_mod      = 1'b0;
    w_addr_err = 1'b0;
    if (req_vaddr_i[31] && cp0_status_i[4]) begin
      w_addr_err = 1'b1;
    end else if (req_vaddr_i[31:30] == 2'b10) begin
      w_paddr = {3'b000, req_vaddr_i[28:0]};
    end else if (!w_tr_hit) begin
      w_refill = 1'b1;
    end else if (!w_page[0]) begin
      w_invalid = 1'b1;
    end else if (req_write_i && !w_page[1]) begin
      w_mod = 1'b1;
    end else begin
      w_paddr = {w_page[24:5], req_vaddr_i[11:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_present <= '0;
    end else if (w_we) begin
      r_present[w_wr_idx] <= 1'b1;
    end
  end

  // Entry payload needs no reset: it is only observed through r_present
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_vpn2[w_wr_idx]  <= cp0_entryhi_i[31:13];
      r_asid[w_wr_idx]  <= cp0_entryhi_i[7:0];
      r_g[w_wr_idx]     <= cp0_entrylo0_i[0] & cp0_entrylo1_i[0];
      r_lo[w_wr_idx][0] <= cp0_entrylo0_i[25:1];
      r_lo[w_wr_idx][1] <= cp0_entrylo1_i[25:1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp_valid <= 1'b0;
      r_rw         <= 1'b0;
      r_paddr      <= '0;
      r_refill     <= 1'b0;
      r_invalid    <= 1'b0;
      r_mod        <= 1'b0;
      r_addr_err   <= 1'b0;
    end else if (!cpu_pause_i) begin
      r_resp_valid <= req_valid_i;
      r_rw         <= req_write_i;
      r_paddr      <= req_valid_i ? w_paddr : 32'd0;
      r_refill     <= req_valid_i & w_refill;
      r_invalid    <= req_valid_i & w_invalid;
      r_mod        <= req_valid_i & w_mod;
      r_addr_err   <= req_valid_i & w_addr_err;
    end
  end

  // TLBR read-back and TLBP result; strobes seen during a pause are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      r_probe_ok  <= 1'b0;
      r_probe_idx <= '0;
      r_rd_hi     <= '0;
      r_rd_lo0    <= '0;
      r_rd_lo1    <= '0;
      r_rd_wen    <= 1'b0;
    end else begin
      r_rd_wen <= ~cpu_pause_i & w_do_r;
      if (!cpu_pause_i && w_do_p) begin
        r_probe_ok  <= w_pb_hit;
        r_probe_idx <= w_pb_idx;
      end
      if (!cpu_pause_i && w_do_r) begin
        if (r_present[w_rd_idx]) begin
          r_rd_hi  <= {r_vpn2[w_rd_idx], 5'b0, r_asid[w_rd_idx]};
          r_rd_lo0 <= {6'b0, r_lo[w_rd_idx][0], r_g[w_rd_idx]};
          r_rd_lo1 <= {6'b0, r_lo[w_rd_idx][1], r_g[w_rd_idx]};
        end else begin
          r_rd_hi  <= '0;
          r_rd_lo0 <= '0;
          r_rd_lo1 <= '0;
        end
      end
    end
  end

  assign resp_valid_o            = r_resp_valid;
  assign resp_paddr_o            = r_paddr;
  assign exception_tlb_refill_o  = r_refill;
  assign exception_tlb_invalid_o = r_invalid;
  assign exception_tlb_mod_o     = r_mod;
  assign exception_addr_error_o  = r_addr_err;
  assign exception_tlb_rw_o      = r_rw;
  assign tlb_probe_success_o     = r_probe_ok;
  assign tlb_probe_index_o       = r_probe_idx;
  assign tlb_entryhi_o           = r_rd_hi;
  assign tlb_entrylo0_o          = r_rd_lo0;
  assign tlb_entrylo1_o          = r_rd_lo1;
  assign tlb_entryhi_wen_o       = r_rd_wen;
  assign tlb_entrylo0_wen_o      = r_rd_wen;
  assign tlb_entrylo1_wen_o      = r_rd_wen;

endmodule

// File: tb/tb_tlb_unit.sv
// Directed bench for tlb_unit: hand-computed expectations checked with immediate assertions.
module tb_tlb_unit;
  localparam int unsigned IDX_W = 4;

  logic clk, reset, cpu_pause_i;
  logic instr_TLBWI_i, instr_TLBWR_i, instr_TLBR_i, instr_TLBP_i;
  logic [31:0] cp0_index_i, cp0_random_i, cp0_entryhi_i, cp0_entrylo0_i, cp0_entrylo1_i, cp0_status_i;
  logic req_valid_i, req_write_i;
  logic [31:0] req_vaddr_i;
  logic resp_valid_o;
  logic [31:0] resp_paddr_o;
  logic exception_tlb_refill_o, exception_tlb_invalid_o, exception_tlb_mod_o;
  logic exception_addr_error_o, exception_tlb_rw_o;
  logic tlb_probe_success_o;
  logic [IDX_W-1:0] tlb_probe_index_o;
  logic [31:0] tlb_entryhi_o, tlb_entrylo0_o, tlb_entrylo1_o;
  logic tlb_entryhi_wen_o, tlb_entrylo0_wen_o, tlb_entrylo1_wen_o;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  tlb_unit #(.ENTRIES(16), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .cpu_pause_i(cpu_pause_i),
    .instr_TLBWI_i(instr_TLBWI_i), .instr_TLBWR_i(instr_TLBWR_i),
    .instr_TLBR_i(instr_TLBR_i), .instr_TLBP_i(instr_TLBP_i),
    .cp0_index_i(cp0_index_i), .cp0_random_i(cp0_random_i), .cp0_entryhi_i(cp0_entryhi_i),
    .cp0_entrylo0_i(cp0_entrylo0_i), .cp0_entrylo1_i(cp0_entrylo1_i), .cp0_status_i(cp0_status_i),
    .req_valid_i(req_valid_i), .req_vaddr_i(req_vaddr_i), .req_write_i(req_write_i),
    .resp_valid_o(resp_valid_o), .resp_paddr_o(resp_paddr_o),
    .exception_tlb_refill_o(exception_tlb_refill_o), .exception_tlb_invalid_o(exception_tlb_invalid_o),
    .exception_tlb_mod_o(exception_tlb_mod_o), .exception_addr_error_o(exception_addr_error_o),
    .exception_tlb_rw_o(exception_tlb_rw_o),
    .tlb_probe_success_o(tlb_probe_success_o), .tlb_probe_index_o(tlb_probe_index_o),
    .tlb_entryhi_o(tlb_entryhi_o), .tlb_entrylo0_o(tlb_entrylo0_o), .tlb_entrylo1_o(tlb_entrylo1_o),
    .tlb_entryhi_wen_o(tlb_entryhi_wen_o), .tlb_entrylo0_wen_o(tlb_entrylo0_wen_o),
    .tlb_entrylo1_wen_o(tlb_entrylo1_wen_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Exception flags packed as {refill, invalid, mod, addr_error}
  function automatic logic [31:0] flags();
    return {28'd0, exception_tlb_refill_o, exception_tlb_invalid_o,
            exception_tlb_mod_o, exception_addr_error_o};
  endfunction

  task automatic xlate(input logic [31:0] va, input logic wr);
    req_valid_i = 1'b1;
    req_vaddr_i = va;
    req_write_i = wr;
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic tlbwi(input logic [31:0] idx, input logic [31:0] hi,
                       input logic [31:0] lo0, input logic [31:0] lo1);
    cp0_index_i    = idx;
    cp0_entryhi_i  = hi;
    cp0_entrylo0_i = lo0;
    cp0_entrylo1_i = lo1;
    instr_TLBWI_i  = 1'b1;
    tick();
    instr_TLBWI_i  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cpu_pause_i = 1'b0;
    instr_TLBWI_i = 1'b0; instr_TLBWR_i = 1'b0; instr_TLBR_i = 1'b0; instr_TLBP_i = 1'b0;
    cp0_index_i = '0; cp0_random_i = '0; cp0_entryhi_i = '0;
    cp0_entrylo0_i = '0; cp0_entrylo1_i = '0; cp0_status_i = '0;
    req_valid_i = 1'b0; req_vaddr_i = '0; req_write_i = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    chk("rst_flags", flags(), 32'd0);
    chk("rst_probe", 32'(tlb_probe_success_o), 32'd0);
    chk("rst_wen", 32'(tlb_entryhi_wen_o), 32'd0);

    // Empty TLB: mapped load refills, kseg0 is unmapped
    xlate(32'h0040_0000, 1'b0);
    chk("t1_valid", 32'(resp_valid_o), 32'd1);
    chk("t1_refill", flags(), 32'b1000);
    chk("t1_paddr", resp_paddr_o, 32'd0);
    xlate(32'h8000_1234, 1'b0);
    chk("t1_kseg0", resp_paddr_o, 32'h0000_1234);
    chk("t1_kseg0_flags", flags(), 32'd0);
    tick();
    chk("t1_idle_valid", 32'(resp_valid_o), 32'd0);

    // Entry 3: vpn2 0x201, ASID 5, even page pfn 0x12345 C2 D1 V1 (lo = pfn<<6 | 0x16), odd invalid
    tlbwi(32'd3, 32'h0040_2005, 32'h0048_D156, 32'h0000_0000);
    xlate(32'h0040_2ABC, 1'b0);
    chk("t2_hit_paddr", resp_paddr_o, 32'h1234_5ABC);
    chk("t2_hit_flags", flags(), 32'd0);
    xlate(32'h0040_3ABC, 1'b0);
    chk("t2_odd_invalid", flags(), 32'b0100);
    chk("t2_odd_paddr", resp_paddr_o, 32'd0);

    // ASID mismatch refills; global rewrite hits regardless of ASID
    cp0_entryhi_i = 32'h0040_2006;
    xlate(32'h0040_2ABC, 1'b0);
    chk("t3_asid_refill", flags(), 32'b1000);
    tlbwi(32'd3, 32'h0040_2005, 32'h0048_D157, 32'h0000_0001);
    cp0_entryhi_i = 32'h0040_2006;
    xlate(32'h0040_2ABC, 1'b0);
    chk("t3_global_paddr", resp_paddr_o, 32'h1234_5ABC);
    chk("t3_global_flags", flags(), 32'd0);

    // Clean page: store raises mod, load translates
    tlbwi(32'd3, 32'h0040_2005, 32'h0048_D152, 32'h0000_0000);
    xlate(32'h0040_2ABC, 1'b1);
    chk("t4_mod", flags(), 32'b0010);
    chk("t4_rw", 32'(exception_tlb_rw_o), 32'd1);
    chk("t4_mod_paddr", resp_paddr_o, 32'd0);
    xlate(32'h0040_2ABC, 1'b0);
    chk("t4_load_paddr", resp_paddr_o, 32'h1234_5ABC);
    chk("t4_load_rw", 32'(exception_tlb_rw_o), 32'd0);

    // TLBP hit, held; then TLBP miss
    cp0_entryhi_i = 32'h0040_2005;
    instr_TLBP_i = 1'b1; tick(); instr_TLBP_i = 1'b0;
    tick();
    chk("t5_probe_ok", 32'(tlb_probe_success_o), 32'd1);
    chk("t5_probe_idx", 32'(tlb_probe_index_o), 32'd3);
    cp0_entryhi_i = 32'h00C0_0005;
    instr_TLBP_i = 1'b1; tick(); instr_TLBP_i = 1'b0;
    chk("t5_probe_miss", 32'(tlb_probe_success_o), 32'd0);
    chk("t5_probe_miss_idx", 32'(tlb_probe_index_o), 32'd0);

    // TLBR index 3: one-cycle write strobes, data held afterwards
    cp0_index_i = 32'd3;
    instr_TLBR_i = 1'b1; tick(); instr_TLBR_i = 1'b0;
    chk("t5_rd_wen", {29'd0, tlb_entryhi_wen_o, tlb_entrylo0_wen_o, tlb_entrylo1_wen_o}, 32'b111);
    chk("t5_rd_hi", tlb_entryhi_o, 32'h0040_2005);
    chk("t5_rd_lo0", tlb_entrylo0_o, 32'h0048_D152);
    chk("t5_rd_lo1", tlb_entrylo1_o, 32'h0000_0000);
    tick();
    chk("t5_rd_wen_drop", {29'd0, tlb_entryhi_wen_o, tlb_entrylo0_wen_o, tlb_entrylo1_wen_o}, 32'd0);
    chk("t5_rd_hi_hold", tlb_entryhi_o, 32'h0040_2005);
    // TLBR of a never-written entry reads zero
    cp0_index_i = 32'd7;
    instr_TLBR_i = 1'b1; tick(); instr_TLBR_i = 1'b0;
    chk("t5_rd_empty_hi", tlb_entryhi_o, 32'd0);
    chk("t5_rd_empty_lo0", tlb_entrylo0_o, 32'd0);
    // TLBWI outranks TLBP in the same cycle: probe result must not change
    cp0_entryhi_i = 32'h0040_2005; cp0_index_i = 32'd9;
    instr_TLBP_i = 1'b1; instr_TLBWI_i = 1'b1; tick();
    instr_TLBP_i = 1'b0; instr_TLBWI_i = 1'b0;
    chk("t5_prio_probe", 32'(tlb_probe_success_o), 32'd0);

    // User mode kernel address: address error only
    cp0_status_i = 32'h0000_0010;
    xlate(32'h8000_0000, 1'b0);
    chk("t5_addr_err", flags(), 32'b0001);
    chk("t5_addr_err_paddr", resp_paddr_o, 32'd0);
    cp0_status_i = 32'd0;

    // Paused write is dropped and translation outputs hold
    cpu_pause_i = 1'b1;
    req_valid_i = 1'b1; req_vaddr_i = 32'h0040_0000;
    tlbwi(32'd5, 32'h0080_0005, 32'h0000_0042, 32'h0000_0042);
    chk("t6_pause_hold", flags(), 32'b0001);
    chk("t6_pause_wen", 32'(tlb_entryhi_wen_o), 32'd0);
    cpu_pause_i = 1'b0;
    req_valid_i = 1'b0;
    cp0_entryhi_i = 32'h0080_0005;
    xlate(32'h0080_0000, 1'b0);
    chk("t6_paused_write_miss", flags(), 32'b1000);

    // Reset clears every entry and the probe result
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t6_rst_probe", 32'(tlb_probe_success_o), 32'd0);
    chk("t6_rst_valid", 32'(resp_valid_o), 32'd0);
    cp0_entryhi_i = 32'h0040_2005;
    xlate(32'h0040_2ABC, 1'b0);
    chk("t6_rst_refill", flags(), 32'b1000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
